// File: rtl/seg7_pkg.sv
// Shared constants for the 4-digit multiplexed 7-segment display.
// Contents:
//   NUM_DIGITS - number of digit positions scanned
//   SEG_OFF    - active-high "all segments dark" pattern
//   GLYPHS     - active-high {g,f,e,d,c,b,a} glyphs for hex 0-F
package seg7_pkg;

  localparam int unsigned NUM_DIGITS = 4;

  localparam logic [6:0] SEG_OFF = 7'h00;

  // Index = nibble value; lowercase b and d keep them distinct from 8 and 0.
  localparam logic [6:0] GLYPHS [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F,  // 0 1 2 3
    7'h66, 7'h6D, 7'h7D, 7'h07,  // 4 5 6 7
    7'h7F, 7'h6F, 7'h77, 7'h7C,  // 8 9 A b
    7'h39, 7'h5E, 7'h79, 7'h71   // C d E F
  };

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to 7-segment glyph decoder (active-high).
// Ports:
//   nibble  in  4  hex digit 0-F
//   glyph   out 7  segments {g,f,e,d,c,b,a}, 1 = lit
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] glyph
);

  assign glyph = GLYPHS[nibble];

endmodule

// File: rtl/seg7_scan_display.sv
// Time-multiplexed 4-digit common-anode 7-segment display driver.
// Shows a 16-bit value in hex with optional leading-zero blanking, a dark
// gap at the start of every digit slot to suppress ghosting, and a decimal
// point flash on digit 0 after each load pulse.
// Ports:
//   clk       in   1   system clock
//   rst       in   1   synchronous active-high reset
//   value     in   16  count to display
//   load      in   1   capture value now and restart the DP flash
//   blank_lz  in   1   blank leading zero digits
//   an        out  4   anode enables, an[0] = least significant digit
//   seg       out  7   segments {g,f,e,d,c,b,a}
//   dp        out  1   decimal point
module seg7_scan_display
  import seg7_pkg::*;
#(
  parameter int unsigned REFRESH_DIV  = 100000,
  parameter int unsigned GAP_CYCLES   = 500,
  parameter int unsigned FLASH_CYCLES = 5000000,
  parameter bit          ACTIVE_LOW   = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] value,
  input  logic        load,
  input  logic        blank_lz,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int unsigned PW = $clog2(REFRESH_DIV);
  localparam int unsigned FW = $clog2(FLASH_CYCLES + 1);
  localparam int unsigned IW = $clog2(NUM_DIGITS);

  localparam logic [PW-1:0] PRESC_MAX  = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0] GAP_END    = PW'(GAP_CYCLES);
  localparam logic [FW-1:0] FLASH_INIT = FW'(FLASH_CYCLES);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [15:0]   shadow_q, shadow_d;
  logic [FW-1:0] flash_q, flash_d;

  logic       slot_end;
  logic       frame_end;
  logic [3:0] nibble;
  logic [6:0] glyph;
  logic       in_gap;
  logic       lz_blank;
  logic       digit_lit;
  logic [3:0] an_hi;
  logic [6:0] seg_hi;
  logic       dp_hi;

  // Next-state logic for the scan counters, shadow register and flash timer.
  always_comb begin
    presc_d   = presc_q + 1'b1;
    idx_d     = idx_q;
    slot_end  = (presc_q == PRESC_MAX);
    frame_end = slot_end && (idx_q == IDX_LAST);
    if (slot_end) begin
      presc_d = '0;
      idx_d   = idx_q + 1'b1;
    end
    // Shadow only updates on load or at frame start, so a frame never tears.
    shadow_d = (load || frame_end) ? value : shadow_q;
    if (load) begin
      flash_d = FLASH_INIT;
    end else if (flash_q != '0) begin
      flash_d = flash_q - 1'b1;
    end else begin
      flash_d = flash_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q  <= '0;
      idx_q    <= '0;
      shadow_q <= 16'h0000;
      flash_q  <= '0;
    end else begin
      presc_q  <= presc_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      flash_q  <= flash_d;
    end
  end

  assign nibble = shadow_q[{idx_q, 2'b00} +: 4];

  seg7_hex_decode u_hex_decode (
    .nibble (nibble),
    .glyph  (glyph)
  );

  // Active-high view of the current slot; polarity is applied at the registers.
  always_comb begin
    in_gap    = (presc_q < GAP_END);
    // Nibbles idx..3 all zero <=> shadow shifted down to this digit is zero.
    lz_blank  = blank_lz && (idx_q != '0) && ((shadow_q >> {idx_q, 2'b00}) == 16'h0000);
    digit_lit = !in_gap && !lz_blank;
    an_hi     = digit_lit ? (4'b0001 << idx_q) : 4'b0000;
    seg_hi    = digit_lit ? glyph : SEG_OFF;
    dp_hi     = !in_gap && (idx_q == '0) && (flash_q != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      an  <= {4{ACTIVE_LOW}};
      seg <= {7{ACTIVE_LOW}};
      dp  <= ACTIVE_LOW;
    end else begin
      an  <= an_hi ^ {4{ACTIVE_LOW}};
      seg <= seg_hi ^ {7{ACTIVE_LOW}};
      dp  <= dp_hi ^ ACTIVE_LOW;
    end
  end

endmodule

// File: tb/tb_seg7_scan_display.sv
// Directed bench for seg7_scan_display with REFRESH_DIV=8, GAP_CYCLES=2,
// FLASH_CYCLES=20, ACTIVE_LOW=1. Glyphs below are the hand-computed
// active-low segment codes for the digits each phase should display.
module tb_seg7_scan_display;

  localparam int DIV   = 8;
  localparam int GAP   = 2;
  localparam int FLASH = 20;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] value;
  logic        load;
  logic        blank_lz;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  int errors = 0;
  int checks = 0;
  int cyc;        // output-sample index since reset release (-1 while in reset)
  int last_load;  // cyc index of the edge that sampled the latest load
  int t0;
  bit armed = 1'b0;

  logic [6:0] exp_glyph [4];
  logic [3:0] exp_lit;

  always #5 clk = ~clk;

  seg7_scan_display #(
    .REFRESH_DIV  (DIV),
    .GAP_CYCLES   (GAP),
    .FLASH_CYCLES (FLASH),
    .ACTIVE_LOW   (1'b1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .value    (value),
    .load     (load),
    .blank_lz (blank_lz),
    .an       (an),
    .seg      (seg),
    .dp       (dp)
  );

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    logic r;
    logic l;
    r = rst;
    l = load;
    @(posedge clk);
    #1;
    if (r) begin
      cyc       = -1;
      last_load = -100;
    end else begin
      cyc++;
      if (l) last_load = cyc;
    end
    armed = 1'b1;
  endtask

  task automatic set_disp(input logic [6:0] g0, input logic [6:0] g1, input logic [6:0] g2,
                          input logic [6:0] g3, input logic [3:0] lit);
    exp_glyph[0] = g0;
    exp_glyph[1] = g1;
    exp_glyph[2] = g2;
    exp_glyph[3] = g3;
    exp_lit      = lit;
  endtask

  task automatic check_cycle();
    int j;
    int d;
    logic lit;
    logic [3:0] an_e;
    logic [6:0] seg_e;
    logic dp_e;
    j     = cyc % DIV;
    d     = (cyc / DIV) % 4;
    lit   = (j >= GAP) && exp_lit[d];
    an_e  = lit ? ~(4'b0001 << d) : 4'hF;
    seg_e = lit ? exp_glyph[d] : 7'h7F;
    dp_e  = !((j >= GAP) && (d == 0) && (cyc > last_load) && (cyc <= last_load + FLASH));
    check_eq("an", {12'h0, an}, {12'h0, an_e});
    check_eq("seg", {9'h0, seg}, {9'h0, seg_e});
    check_eq("dp", {15'h0, dp}, {15'h0, dp_e});
  endtask

  task automatic step_check();
    step();
    if (cyc >= 0) check_cycle();
  endtask

  task automatic check_off(input string tag);
    check_eq({tag, "_an"}, {12'h0, an}, 16'h000F);
    check_eq({tag, "_seg"}, {9'h0, seg}, 16'h007F);
    check_eq({tag, "_dp"}, {15'h0, dp}, 16'h0001);
  endtask

  // At most one anode may ever be driven.
  always @(negedge clk) begin
    if (armed) check_eq("onehot", {15'h0, ($countones(~an) <= 1)}, 16'h0001);
  end

  initial begin
    rst       = 1'b1;
    load      = 1'b0;
    value     = 16'h0000;
    blank_lz  = 1'b0;
    cyc       = -1;
    last_load = -100;

    // Reset: outputs dark.
    repeat (3) begin
      step();
      check_off("rst");
    end
    rst = 1'b0;

    // Shadow 0000, no blanking: four "0" digits, first lit slot an=1110.
    set_disp(7'h40, 7'h40, 7'h40, 7'h40, 4'b1111);
    repeat (3) step_check();
    check_eq("first_lit_an", {12'h0, an}, 16'h000E);
    check_eq("first_lit_seg", {9'h0, seg}, 16'h0040);
    while (cyc % 32 != 30) step_check();

    // 1A3F: digits F,3,A,1.
    value = 16'h1A3F;
    load  = 1'b1;
    step_check();
    load  = 1'b0;
    set_disp(7'h0E, 7'h30, 7'h08, 7'h79, 4'b1111);
    repeat (32) step_check();
    while (cyc % 32 != 30) step_check();

    // 0005 with blanking: only digit 0 lit.
    value    = 16'h0005;
    blank_lz = 1'b1;
    load     = 1'b1;
    step_check();
    load     = 1'b0;
    set_disp(7'h12, 7'h7F, 7'h7F, 7'h7F, 4'b0001);
    repeat (32) step_check();

    // Value changes mid-frame without load: no effect until frame start.
    repeat (9) step_check();
    value = 16'h2222;
    while (cyc % 32 != 31) step_check();
    set_disp(7'h24, 7'h24, 7'h24, 7'h24, 4'b1111);
    repeat (32) step_check();

    // Two loads 10 cycles apart: flash runs 20 cycles from the second.
    t0 = cyc + 5;
    repeat (64) begin
      load = ((cyc + 1) == t0) || ((cyc + 1) == t0 + 10);
      step_check();
    end
    load = 1'b0;

    // BEEF, then reset in the middle of the digit-1 slot.
    while (cyc % 32 != 30) step_check();
    value    = 16'hBEEF;
    blank_lz = 1'b0;
    load     = 1'b1;
    step_check();
    load     = 1'b0;
    set_disp(7'h0E, 7'h06, 7'h06, 7'h03, 4'b1111);
    repeat (12) step_check();
    rst   = 1'b1;
    value = 16'h0000;
    step();
    check_off("midrst");
    step();
    check_off("midrst2");
    rst = 1'b0;
    set_disp(7'h40, 7'h40, 7'h40, 7'h40, 4'b1111);
    repeat (32) step_check();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
